video_tpg: RTL and testbench

VIDEO_TPG -- requirements
Module: video_tpg

---
 rtl/video_tpg.sv | 214 +++++++++++++++++++++
 tb/tb_video_tpg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/video_tpg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// video_tpg : raster timing generator with colour-bar/ramp/checker/solid
//             test patterns and fully registered video outputs.  Rev 1.0
// ---------------------------------------------------------------------------
module video_tpg #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter int SYNC_POL = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [1:0]  pattern_sel,
   input  logic [23:0] solid_rgb_i,
   output logic [23:0] rgb_o,
   output logic        dv_o,
   output logic        hs_o,
   output logic        vs_o,
   output logic        line_end,
   output logic        frame_start
);

   localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // Counters are at least 8/6 bits wide so the ramp and checker bit taps always exist.
   localparam int c_hw      = ($clog2(c_h_total) > 8) ? $clog2(c_h_total) : 8;
   localparam int c_vw      = ($clog2(c_v_total) > 6) ? $clog2(c_v_total) : 6;
   localparam int c_bar_w   = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;
   localparam int c_bw      = ($clog2(c_bar_w) > 0) ? $clog2(c_bar_w) : 1;

   localparam logic [c_hw-1:0] c_h_last     = c_hw'(c_h_total - 1);
   localparam logic [c_hw-1:0] c_h_act      = c_hw'(H_ACTIVE);
   localparam logic [c_hw-1:0] c_h_act_last = c_hw'(H_ACTIVE - 1);
   localparam logic [c_hw-1:0] c_hs_beg     = c_hw'(H_ACTIVE + H_FP);
   localparam logic [c_hw-1:0] c_hs_end     = c_hw'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [c_vw-1:0] c_v_last     = c_vw'(c_v_total - 1);
   localparam logic [c_vw-1:0] c_v_act      = c_vw'(V_ACTIVE);
   localparam logic [c_vw-1:0] c_vs_beg     = c_vw'(V_ACTIVE + V_FP);
   localparam logic [c_vw-1:0] c_vs_end     = c_vw'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [c_bw-1:0] c_bar_last   = c_bw'(c_bar_w - 1);
   localparam logic            c_pol        = (SYNC_POL != 0);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_q,   state_d;
   logic [c_hw-1:0]   hcnt_q,    hcnt_d;
   logic [c_vw-1:0]   vcnt_q,    vcnt_d;
   logic [c_bw-1:0]   bar_pix_q, bar_pix_d;
   logic [2:0]        bar_idx_q, bar_idx_d;
   logic [1:0]        pat_q,     pat_d;
   logic [23:0]       solid_q,   solid_d;
   logic [23:0]       rgb_q,     rgb_d;
   logic              dv_q,      dv_d;
   logic              hs_q,      hs_d;
   logic              vs_q,      vs_d;
   logic              le_q,      le_d;
   logic              fs_q,      fs_d;

   logic              w_origin;
   logic              w_h_wrap;
   logic              w_v_wrap;
   logic              w_sample;
   logic              w_active;
   logic [1:0]        w_pat;
   logic [23:0]       w_solid;
   logic [23:0]       w_colour;

   assign w_origin = (hcnt_q == '0) && (vcnt_q == '0);
   assign w_h_wrap = (hcnt_q == c_h_last);
   assign w_v_wrap = (vcnt_q == c_v_last);
   // Pixel (0,0) already uses the freshly sampled selection, so the whole frame is consistent.
   assign w_sample = w_origin && ((state_q == ST_RUN) || en);
   assign w_pat    = w_sample ? pattern_sel : pat_q;
   assign w_solid  = w_sample ? solid_rgb_i : solid_q;
   assign w_active = (state_q == ST_RUN) && (hcnt_q < c_h_act) && (vcnt_q < c_v_act);

   // Timing FSM and counters
   always_comb begin
      state_d   = state_q;
      hcnt_d    = hcnt_q;
      vcnt_d    = vcnt_q;
      bar_pix_d = bar_pix_q;
      bar_idx_d = bar_idx_q;
      pat_d     = pat_q;
      solid_d   = solid_q;

      if (w_sample) begin
         pat_d   = pattern_sel;
         solid_d = solid_rgb_i;
      end

      case (state_q)
         ST_IDLE: begin
            hcnt_d    = '0;
            vcnt_d    = '0;
            bar_pix_d = '0;
            bar_idx_d = 3'd0;
            if (en) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_h_wrap) begin
               hcnt_d    = '0;
               bar_pix_d = '0;
               bar_idx_d = 3'd0;
               if (w_v_wrap) begin
                  vcnt_d = '0;
                  if (!en) begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  vcnt_d = vcnt_q + c_vw'(1);
               end
            end else begin
               hcnt_d = hcnt_q + c_hw'(1);
               // The last bar absorbs any remainder pixels, so stop advancing there.
               if (bar_idx_q != 3'd7) begin
                  if (bar_pix_q == c_bar_last) begin
                     bar_pix_d = '0;
                     bar_idx_d = bar_idx_q + 3'd1;
                  end else begin
                     bar_pix_d = bar_pix_q + c_bw'(1);
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_colour = 24'h000000;
      case (w_pat)
         2'd0: begin
            case (bar_idx_q)
               3'd0:    w_colour = 24'hFFFFFF;
               3'd1:    w_colour = 24'hFFFF00;
               3'd2:    w_colour = 24'h00FFFF;
               3'd3:    w_colour = 24'h00FF00;
               3'd4:    w_colour = 24'hFF00FF;
               3'd5:    w_colour = 24'hFF0000;
               3'd6:    w_colour = 24'h0000FF;
               default: w_colour = 24'h000000;
            endcase
         end
         2'd1:    w_colour = {3{hcnt_q[7:0]}};
         2'd2:    w_colour = (hcnt_q[5] ^ vcnt_q[5]) ? 24'hFFFFFF : 24'h000000;
         default: w_colour = w_solid;
      endcase
   end

   always_comb begin
      rgb_d = w_active ? w_colour : 24'h000000;
      dv_d  = w_active;
      le_d  = w_active && (hcnt_q == c_h_act_last);
      fs_d  = w_active && w_origin;
      hs_d  = ((hcnt_q >= c_hs_beg) && (hcnt_q < c_hs_end)) ? c_pol : ~c_pol;
      vs_d  = ((vcnt_q >= c_vs_beg) && (vcnt_q < c_vs_end)) ? c_pol : ~c_pol;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         hcnt_q    <= '0;
         vcnt_q    <= '0;
         bar_pix_q <= '0;
         bar_idx_q <= 3'd0;
         pat_q     <= 2'd0;
         solid_q   <= 24'h000000;
         rgb_q     <= 24'h000000;
         dv_q      <= 1'b0;
         hs_q      <= ~c_pol;
         vs_q      <= ~c_pol;
         le_q      <= 1'b0;
         fs_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         hcnt_q    <= hcnt_d;
         vcnt_q    <= vcnt_d;
         bar_pix_q <= bar_pix_d;
         bar_idx_q <= bar_idx_d;
         pat_q     <= pat_d;
         solid_q   <= solid_d;
         rgb_q     <= rgb_d;
         dv_q      <= dv_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         le_q      <= le_d;
         fs_q      <= fs_d;
      end
   end

   assign rgb_o       = rgb_q;
   assign dv_o        = dv_q;
   assign hs_o        = hs_q;
   assign vs_o        = vs_q;
   assign line_end    = le_q;
   assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_video_tpg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_video_tpg : randomized bench for video_tpg against a frame-position
//                reference model.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_video_tpg;

   localparam int HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [1:0]  pattern_sel;
   logic [23:0] solid_rgb_i;
   logic [23:0] rgb_o;
   logic        dv_o, hs_o, vs_o, line_end, frame_start;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   video_tpg #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1)
   ) u_dut (
      .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
      .solid_rgb_i(solid_rgb_i), .rgb_o(rgb_o), .dv_o(dv_o), .hs_o(hs_o),
      .vs_o(vs_o), .line_end(line_end), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: one integer frame position, decoded with plain arithmetic.
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
   bit          m_run;
   int          m_p;
   logic [1:0]  m_pat;
   logic [23:0] m_solid;
   logic [23:0] e_rgb;
   logic        e_dv, e_hs, e_vs, e_le, e_fs;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_run <= 1'b0; m_p <= 0; m_pat <= 2'd0; m_solid <= 24'h0;
         e_rgb <= 24'h0; e_dv <= 1'b0; e_hs <= 1'b0; e_vs <= 1'b0;
         e_le <= 1'b0; e_fs <= 1'b0;
      end else begin : step
         int h, v, bi;
         logic [1:0]  pat;
         logic [23:0] sol, col;
         bit act;
         h = m_p % HT;
         v = m_p / HT;
         if (!m_run) begin
            e_rgb <= 24'h0; e_dv <= 1'b0; e_hs <= 1'b0; e_vs <= 1'b0;
            e_le <= 1'b0; e_fs <= 1'b0;
            if (en) m_run <= 1'b1;
         end else begin
            pat = (m_p == 0) ? pattern_sel : m_pat;
            sol = (m_p == 0) ? solid_rgb_i : m_solid;
            if (m_p == 0) begin
               m_pat   <= pattern_sel;
               m_solid <= solid_rgb_i;
            end
            act = (h < HA) && (v < VA);
            bi  = h / (HA / 8);
            if (bi > 7) bi = 7;
            case (pat)
               2'd0:    col = bars[bi];
               2'd1:    col = {3{8'(h)}};
               2'd2:    col = ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
               default: col = sol;
            endcase
            e_rgb <= act ? col : 24'h0;
            e_dv  <= act;
            e_le  <= act && (h == HA - 1);
            e_fs  <= (m_p == 0);
            e_hs  <= (h >= HA + HF) && (h < HA + HF + HS);
            e_vs  <= (v >= VA + VF) && (v < VA + VF + VS);
            if (m_p == FT - 1) begin
               m_p <= 0;
               if (!en) m_run <= 1'b0;
            end else begin
               m_p <= m_p + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("rgb", rgb_o, e_rgb);
         check("dv", dv_o, e_dv);
         check("hs", hs_o, e_hs);
         check("vs", vs_o, e_vs);
         check("line_end", line_end, e_le);
         check("frame_start", frame_start, e_fs);
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rgb"}, rgb_o, 24'h0);
      check({tag, "_dv"}, dv_o, 1'b0);
      check({tag, "_hs"}, hs_o, 1'b0);
      check({tag, "_vs"}, vs_o, 1'b0);
      check({tag, "_le"}, line_end, 1'b0);
      check({tag, "_fs"}, frame_start, 1'b0);
   endtask

   // Reset is asserted between clock edges and checked before any edge arrives.
   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      #1 check_reset_outputs("async_rst");
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic fs_latency(input string tag);
      int wt = 0;
      do begin
         @(negedge clk);
         wt++;
      end while (!frame_start && wt < 400);
      check(tag, wt, 2);
   endtask

   initial begin
      int per, ndv, nle, nhs, nvs, nbad, dvvs;
      rst = 1'b0; en = 1'b0; pattern_sel = 2'd0; solid_rgb_i = 24'h0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      cmp_en = 1'b1;

      pattern_sel = 2'd3; solid_rgb_i = 24'h123456; en = 1'b1; rst = 1'b1;
      fs_latency("fs_latency");

      per = 0; ndv = 0; nle = 0; nhs = 0; nvs = 0; nbad = 0; dvvs = 0;
      do begin
         if (dv_o) begin
            ndv++;
            if (rgb_o !== 24'h123456) nbad++;
         end
         nle += int'(line_end);
         nhs += int'(hs_o);
         nvs += int'(vs_o);
         if (dv_o && vs_o) dvvs++;
         @(negedge clk);
         per++;
      end while (!frame_start && per < 400);
      check("frame_period", per, FT);
      check("dv_per_frame", ndv, HA * VA);
      check("line_end_per_frame", nle, VA);
      check("hs_per_frame", nhs, HS * VT);
      check("vs_per_frame", nvs, VS * HT);
      check("solid_pixels_bad", nbad, 0);
      check("dv_during_vs", dvvs, 0);

      // Dropping en right after frame start must still let the frame finish.
      en = 1'b0;
      ndv = 0;
      for (int c = 0; c < 250; c++) begin
         ndv += int'(dv_o);
         @(negedge clk);
      end
      check("dv_after_en_drop", ndv, HA * VA);
      check("idle_dv", dv_o, 1'b0);
      en = 1'b1;
      fs_latency("fs_restart");

      repeat (2 * HT + 6) @(negedge clk);
      do_reset();
      fs_latency("fs_after_reset");

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 149) == 0) en = ~en;
         if ($urandom_range(0, 39) == 0)  pattern_sel = 2'($urandom);
         if ($urandom_range(0, 39) == 0)  solid_rgb_i = 24'($urandom);
         if ($urandom_range(0, 999) == 0) do_reset();
      end

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
